sram_like_responder: RTL and testbench



---
 rtl/sram_like_pkg.sv | 17 +
 rtl/sram_like_responder_resp_queue.sv | 43 ++++
 rtl/sram_like_responder.sv | 65 ++++++
 tb/tb_sram_like_responder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared size codes, response-queue entry type and the stall LFSR constants.
package sram_like_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam int CNT_W = 8;
  typedef struct packed {
    logic wr;
    logic [31:0] data;
    logic [CNT_W-1:0] cnt;
  } entry_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci form, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
endpackage

// File: rtl/sram_like_responder_resp_queue.sv
// resp_queue: circular FIFO of response entries, each counting down its own latency.
//   clk, resetn    : clock, asynchronous active-low reset
//   push/push_entry: enqueue one entry
//   pop            : dequeue the head
//   head           : oldest entry
//   count/full/empty: occupancy
module resp_queue import sram_like_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  entry_t q [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      // every slot ticks down; stale slots are harmless since they are overwritten on push
      for (int i = 0; i < DEPTH; i++)
        if (q[i].cnt != '0) q[i].cnt <= q[i].cnt - 1'b1;
      if (push) begin
        q[wp] <= push_entry;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  assign head  = q[rp];
  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: word-addressed memory answering the sram-like req/addr_ok/data_ok bus in order.
//   clk, resetn : clock, asynchronous active-low reset
//   req, wr, size, wstrb, addr, wdata : request from the master (size informational, wstrb authoritative)
//   addr_ok     : request accepted this cycle
//   data_ok     : one-cycle response for the oldest outstanding request
//   rdata       : read data with data_ok, 0 for writes and when idle
// Optional: define SRAM_RESP_RANDSTALL_EN for LFSR-driven random accept/response stalls.
module sram_like_responder import sram_like_pkg::*; #(
  parameter int MEM_AW      = 10,
  parameter int OUTSTANDING = 4,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  logic [31:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  entry_t head, push_entry;
  logic [$clog2(OUTSTANDING):0] count;
  logic full, empty, stall_req, stall_rsp;
  logic unused;
  assign unused = ^{size, addr[31:MEM_AW+2], addr[1:0], count, head.wr};
  assign idx = addr[MEM_AW+1:2];
`ifdef SRAM_RESP_RANDSTALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lfsr <= LFSR_SEED;
    else lfsr <= lfsr_next(lfsr);
  assign stall_req = lfsr[0];
  assign stall_rsp = lfsr[1];
`else
  assign stall_req = 1'b0;
  assign stall_rsp = 1'b0;
`endif
  // full blocks acceptance even when the head pops this cycle
  assign addr_ok = req & resetn & ~full & ~stall_req;
  // outputs decode straight from queue registers, so an entry answers LATENCY cycles after acceptance
  assign data_ok = ~empty & (head.cnt == '0) & ~stall_rsp;
  assign rdata   = data_ok ? head.data : '0;
  assign push_entry = '{wr: wr, data: wr ? 32'h0 : mem[idx], cnt: CNT_W'(LATENCY - 1)};
  always_ff @(posedge clk)
    if (addr_ok && wr)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  resp_queue #(.DEPTH(OUTSTANDING)) u_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (addr_ok),
    .push_entry (push_entry),
    .pop        (data_ok),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: directed + random checks of sram_like_responder against a queue/array reference model.
module tb_sram_like_responder;
  localparam int L = 2;
  localparam int OUT = 4;
  typedef struct {
    logic [31:0] d;
    int t;
  } exp_t;
  logic clk, resetn, req, wr, addr_ok, data_ok;
  logic [1:0] size;
  logic [3:0] wstrb;
  logic [31:0] addr, wdata, rdata;
  int checks, errors, cyc;
  logic acc;
  logic [31:0] mm [1024];
  exp_t q [$];

  sram_like_responder #(.MEM_AW(10), .OUTSTANDING(OUT), .LATENCY(L)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // one bus cycle: sample outputs mid-cycle, update the model, advance to next negedge
  task automatic tick();
    logic exp_aok, exp_dok;
    logic [9:0] i;
    #1;
    exp_aok = resetn && req && (q.size() < OUT);
`ifdef SRAM_RESP_RANDSTALL_EN
    chk("addr_ok_legal", 32'(addr_ok && !exp_aok), 32'd0);
`else
    chk("addr_ok", 32'(addr_ok), 32'(exp_aok));
    exp_dok = 1'b0;
    if (q.size() != 0) exp_dok = (q[0].t + L == cyc);
    chk("data_ok", 32'(data_ok), 32'(exp_dok));
`endif
    if (data_ok) begin
      chk("data_ok_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        chk("rdata", rdata, q[0].d);
        chk("latency_min", 32'(cyc - q[0].t >= L), 32'd1);
        void'(q.pop_front());
      end
    end else if (q.size() == 0) chk("rdata_idle", rdata, 32'd0);
    acc = addr_ok;
    if (addr_ok) begin
      i = addr[11:2];
      q.push_back('{wr ? 32'h0 : mm[i], cyc});
      if (wr) for (int b = 0; b < 4; b++) if (wstrb[b]) mm[i][8*b +: 8] = wdata[8*b +: 8];
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'($urandom_range(0, 2));
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) tick();
    chk("issue_accepted", 32'(acc), 32'd1);
    req = 1'b0;
  endtask

  task automatic drain();
    req = 1'b0;
    for (int n = 0; n < 200 && q.size() != 0; n++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int start;
    logic [31:0] a;
    checks = 0; errors = 0; cyc = 0;
    resetn = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = '0; wdata = '0;
    #2 resetn = 1'b0;
    @(negedge clk);
    req = 1'b1;
    tick();
    chk("reset_data_ok", 32'(data_ok), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_addr_ok", 32'(addr_ok), 32'd0);
    tick();
    req = 1'b0;
    resetn = 1'b1;
    tick();
    // full-word write/read, then byte-lane merge
    issue(1'b1, 32'h1C00_0010, 32'h1234_5678, 4'hF);
    issue(1'b0, 32'h1C00_0010, 32'h0, 4'h0);
    drain();
    issue(1'b1, 32'h1C00_0010, 32'h0000_AB00, 4'b0010);
    issue(1'b0, 32'h1C00_0012, 32'h0, 4'h0);
    drain();
    chk("byte_merge_model", mm[4], 32'h1234_AB78);
    // five back-to-back reads against four outstanding slots
    for (int k = 0; k < 5; k++) issue(1'b1, 32'h100 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'hF);
    drain();
    for (int k = 0; k < 5; k++) issue(1'b0, 32'h100 + 32'(k * 4), 32'h0, 4'h0);
    drain();
    // aliasing above MEM_AW
    issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    drain();
    chk("alias_model", mm[1], 32'hDEAD_BEEF);
    // reset with two reads in flight
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    issue(1'b0, 32'h104, 32'h0, 4'h0);
    resetn = 1'b0; req = 1'b1; wr = 1'b0; addr = 32'h108;
    q.delete();
    tick();
    chk("midreset_addr_ok", 32'(addr_ok), 32'd0);
    resetn = 1'b1;
    start = cyc;
    issue(1'b0, 32'h108, 32'h0, 4'h0);
`ifndef SRAM_RESP_RANDSTALL_EN
    chk("post_reset_accept_cycles", 32'(cyc - start), 32'd1);
`endif
    drain();
    // random traffic over a pre-initialised window, with aliased and misaligned addresses
    for (int k = 0; k < 16; k++) issue(1'b1, 32'h200 + 32'(k * 4), $urandom, 4'hF);
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) tick();
      a = ($urandom & 32'hFFFF_F000) | ((32'h80 + 32'($urandom_range(0, 15))) << 2) | ($urandom & 32'h3);
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
